// File: rtl/draw_pkg.sv
// Shared definitions for the VGA drawing path: screen geometry, arbiter
// state encoding, palette constants and the round-robin wrap helper.
package draw_pkg;

   // 160x120 adapter mode
   localparam int VGA_X_W = 8;
   localparam int VGA_Y_W = 7;
   localparam int VGA_C_W = 3;

   // Arbiter state encoding (kept as plain constants for legacy tools)
   typedef logic [1:0] arb_state_t;
   localparam arb_state_t ARB_IDLE    = 2'd0;
   localparam arb_state_t ARB_BURST   = 2'd1;
   localparam arb_state_t ARB_RELEASE = 2'd2;

   // Palette entries used by the renderers
   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] CYAN  = 3'b011;
   localparam logic [2:0] WHITE = 3'b111;

   // Next round-robin start position after index idx, wrapping at n
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first asserted request at or
// after the pointer, wrapping modulo N_REQ, and returns it as one-hot and
// as an index.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
)(
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Scan candidates starting at the pointer; the first hit wins
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         int cand;
         cand = (int'(i_ptr) + k) % N_REQ;
         if (!o_any && i_req[cand]) begin
            o_any          = 1'b1;
            o_onehot[cand] = 1'b1;
            o_idx          = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the single vga_adapter plot port between N_REQ drawing clients.
// Round-robin grant per burst; the owner keeps the port until it flags its
// last pixel (or drops req). The winner's pixel is registered onto
// plot/x/y/colour with one cycle of latency.
// Optional feature: define DRAW_ARB_TIMEOUT_EN to bound every burst to
// MAX_BURST cycles and raise the sticky timeout_err flag on overrun.
module vga_draw_arbiter
   import draw_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int X_W       = VGA_X_W,
   parameter int Y_W       = VGA_Y_W,
   parameter int C_W       = VGA_C_W,
   parameter int MAX_BURST = 8192
)(
   input  logic               clk,
   input  logic               resetn,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     px_valid,
   input  logic [N_REQ-1:0]     px_last,
   input  logic [N_REQ*X_W-1:0] px_x,
   input  logic [N_REQ*Y_W-1:0] px_y,
   input  logic [N_REQ*C_W-1:0] px_colour,
   output logic [N_REQ-1:0]     gnt,
   output logic                 busy,
   output logic                 plot,
   output logic [X_W-1:0]       x_to_vga,
   output logic [Y_W-1:0]       y_to_vga,
   output logic [C_W-1:0]       color_to_vga,
   output logic                 timeout_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t       r_state;
   arb_state_t       w_state_next;
   logic [N_REQ-1:0] r_gnt;
   logic [IDX_W-1:0] r_gidx;
   logic [IDX_W-1:0] r_rr_ptr;
   logic             r_plot;
   logic [X_W-1:0]   r_x;
   logic [Y_W-1:0]   r_y;
   logic [C_W-1:0]   r_c;

   logic [N_REQ-1:0] w_pick_onehot;
   logic [IDX_W-1:0] w_pick_idx;
   logic             w_pick_any;

   logic [X_W-1:0]   w_x_arr [N_REQ];
   logic [Y_W-1:0]   w_y_arr [N_REQ];
   logic [C_W-1:0]   w_c_arr [N_REQ];

   logic             w_g_req;
   logic             w_g_valid;
   logic             w_g_last;
   logic             w_exit;
   logic             w_timeout;

   // Unpack the per-client pixel buses
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
         assign w_x_arr[gi] = px_x[gi*X_W +: X_W];
         assign w_y_arr[gi] = px_y[gi*Y_W +: Y_W];
         assign w_c_arr[gi] = px_colour[gi*C_W +: C_W];
      end
   endgenerate

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req    (req),
      .i_ptr    (r_rr_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   // Only the registered owner's signals are ever looked at
   assign w_g_req   = req[r_gidx];
   assign w_g_valid = px_valid[r_gidx];
   assign w_g_last  = px_last[r_gidx];

   // Normal completion (last pixel) or abort (owner withdrew its request)
   assign w_exit = (w_g_valid & w_g_last) | ~w_g_req;

`ifdef DRAW_ARB_TIMEOUT_EN
   localparam int CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

   logic [CNT_W-1:0] r_burst_cnt;
   logic             r_timeout_err;

   // The MAX_BURST-th BURST cycle without an exit forces the release
   assign w_timeout = (r_state == ARB_BURST) && !w_exit &&
                      (r_burst_cnt == CNT_W'(MAX_BURST - 1));

   // Count cycles spent in BURST; anything else restarts the count
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_burst_cnt <= '0;
      else if (r_state == ARB_BURST)
         r_burst_cnt <= r_burst_cnt + 1'b1;
      else
         r_burst_cnt <= '0;
   end

   // Sticky overrun flag, cleared only by reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_timeout_err <= 1'b0;
      else if (w_timeout)
         r_timeout_err <= 1'b1;
   end

   assign timeout_err = r_timeout_err;
`else
   logic w_unused_max_burst;

   // Bursts are unbounded in this build
   assign w_timeout          = 1'b0;
   assign w_unused_max_burst = (MAX_BURST > 0);
   assign timeout_err        = 1'b0;
`endif

   // Next-state logic for IDLE -> BURST -> RELEASE -> IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE:    if (w_pick_any) w_state_next = ARB_BURST;
         ARB_BURST:   if (w_exit || w_timeout) w_state_next = ARB_RELEASE;
         ARB_RELEASE: w_state_next = ARB_IDLE;
         default:     w_state_next = ARB_IDLE;
      endcase
   end

   // State, grant and round-robin pointer registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= ARB_IDLE;
         r_gnt    <= '0;
         r_gidx   <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            ARB_IDLE: begin
               if (w_pick_any) begin
                  r_gnt  <= w_pick_onehot;
                  r_gidx <= w_pick_idx;
               end
            end
            ARB_BURST: begin
               if (w_state_next == ARB_RELEASE)
                  r_gnt <= '0;
            end
            ARB_RELEASE: begin
               // The finished owner moves to the back of the queue
               r_gnt    <= '0;
               r_rr_ptr <= IDX_W'(rr_next(int'(r_gidx), N_REQ));
            end
            default: r_gnt <= '0;
         endcase
      end
   end

   // Register the owner's pixel; plot drops whenever no burst is active
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_plot <= 1'b0;
         r_x    <= '0;
         r_y    <= '0;
         r_c    <= '0;
      end else if (r_state == ARB_BURST) begin
         r_plot <= w_g_valid;
         if (w_g_valid) begin
            r_x <= w_x_arr[r_gidx];
            r_y <= w_y_arr[r_gidx];
            r_c <= w_c_arr[r_gidx];
         end
      end else begin
         r_plot <= 1'b0;
      end
   end

   assign gnt          = r_gnt;
   assign busy         = (r_state != ARB_IDLE);
   assign plot         = r_plot;
   assign x_to_vga     = r_x;
   assign y_to_vga     = r_y;
   assign color_to_vga = r_c;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter (N_REQ=4, MAX_BURST=16).
// Expected timeout behaviour follows DRAW_ARB_TIMEOUT_EN.
module tb_vga_draw_arbiter;

   localparam int N  = 4;
   localparam int XW = 8;
   localparam int YW = 7;
   localparam int CW = 3;
   localparam int MB = 16;
`ifdef DRAW_ARB_TIMEOUT_EN
   localparam int TO = 1;
`else
   localparam int TO = 0;
`endif

   logic           clk       = 1'b0;
   logic           resetn    = 1'b0;
   logic [N-1:0]   req       = '0;
   logic [N-1:0]   px_valid  = '0;
   logic [N-1:0]   px_last   = '0;
   logic [N*XW-1:0] px_x     = '0;
   logic [N*YW-1:0] px_y     = '0;
   logic [N*CW-1:0] px_colour = '0;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           plot;
   logic [XW-1:0]  x_to_vga;
   logic [YW-1:0]  y_to_vga;
   logic [CW-1:0]  color_to_vga;
   logic           timeout_err;

   int total   = 0;
   int bad     = 0;
   int n_plots = 0;

   vga_draw_arbiter #(
      .N_REQ     (N),
      .X_W       (XW),
      .Y_W       (YW),
      .C_W       (CW),
      .MAX_BURST (MB)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req          (req),
      .px_valid     (px_valid),
      .px_last      (px_last),
      .px_x         (px_x),
      .px_y         (px_y),
      .px_colour    (px_colour),
      .gnt          (gnt),
      .busy         (busy),
      .plot         (plot),
      .x_to_vga     (x_to_vga),
      .y_to_vga     (y_to_vga),
      .color_to_vga (color_to_vga),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   // Count plot strobes mid-cycle
   always @(negedge clk) begin
      if (plot === 1'b1) n_plots <= n_plots + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_px(input int i, input logic v, input logic l,
                         input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [CW-1:0] c);
      px_valid[i]          = v;
      px_last[i]           = l;
      px_x[i*XW +: XW]     = x;
      px_y[i*YW +: YW]     = y;
      px_colour[i*CW +: CW] = c;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int e;
      int eg;

      // Reset state
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_plot", 32'(plot), 0);
      chk("rst_xyc", 32'({x_to_vga, y_to_vga, color_to_vga}), 0);
      chk("rst_timeout", 32'(timeout_err), 0);
      resetn = 1'b1;
      tick();

      // 1: single client 0, four pixels (10..13,20) colour 4
      req = 4'b0001;
      chk("t1_pre_gnt", 32'(gnt), 0);
      tick();
      chk("t1_gnt", 32'(gnt), 1);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_noplot", 32'(plot), 0);
      for (int k = 0; k < 4; k++) begin
         set_px(0, 1'b1, (k == 3), 8'(10 + k), 7'd20, 3'b100);
         tick();
         chk("t1_plot", 32'(plot), 1);
         chk("t1_x", 32'(x_to_vga), 10 + k);
         chk("t1_y", 32'(y_to_vga), 20);
         chk("t1_c", 32'(color_to_vga), 4);
         chk("t1_gnt_hold", 32'(gnt), (k == 3) ? 0 : 1);
      end
      chk("t1_rel_busy", 32'(busy), 1);
      req = 4'b0000;
      set_px(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      tick();
      chk("t1_idle_plot", 32'(plot), 0);
      chk("t1_idle_busy", 32'(busy), 0);
      chk("t1_x_hold", 32'(x_to_vga), 13);
      chk("t1_nplots", n_plots, 4);

      // 2: all clients request, one-pixel bursts, order 0,1,2,3,0
      do_reset();
      for (int i = 0; i < N; i++) set_px(i, 1'b1, 1'b1, 8'(40 + i), 7'd5, 3'b011);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         e = k % 4;
         tick();
         chk("t2_gnt", 32'(gnt), 32'(1) << e);
         tick();
         chk("t2_rel_gnt", 32'(gnt), 0);
         chk("t2_plot", 32'(plot), 1);
         chk("t2_x", 32'(x_to_vga), 40 + e);
         tick();
         chk("t2_gap_plot", 32'(plot), 0);
         chk("t2_gap_gnt", 32'(gnt), 0);
         if (k == 4) req = 4'b0000;
      end
      for (int i = 0; i < N; i++) set_px(i, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);

      // 3: client 2 bursting, client 1 intrudes with x=99
      req = 4'b0100;
      tick();
      chk("t3_gnt", 32'(gnt), 4);
      set_px(2, 1'b1, 1'b0, 8'd50, 7'd30, 3'd7);
      req[1] = 1'b1;
      set_px(1, 1'b1, 1'b1, 8'd99, 7'd31, 3'd1);
      tick();
      chk("t3_x0", 32'(x_to_vga), 50);
      chk("t3_gnt_hold", 32'(gnt), 4);
      set_px(2, 1'b1, 1'b1, 8'd51, 7'd30, 3'd7);
      tick();
      chk("t3_x1", 32'(x_to_vga), 51);
      chk("t3_rel_gnt", 32'(gnt), 0);
      req[2] = 1'b0;
      set_px(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      tick();
      chk("t3_idle_x", 32'(x_to_vga), 51);
      chk("t3_idle_plot", 32'(plot), 0);
      tick();
      chk("t3_next_gnt", 32'(gnt), 2);
      chk("t3_next_noplot", 32'(plot), 0);
      tick();
      chk("t3_x99", 32'(x_to_vga), 99);
      chk("t3_x99_plot", 32'(plot), 1);
      chk("t3_x99_rel", 32'(gnt), 0);
      req = 4'b0000;
      set_px(1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      tick();

      // 4: client 3 aborts after two pixels
      p0 = n_plots;
      req = 4'b1000;
      tick();
      chk("t4_gnt", 32'(gnt), 8);
      set_px(3, 1'b1, 1'b0, 8'd70, 7'd40, 3'd2);
      tick();
      chk("t4_x0", 32'(x_to_vga), 70);
      set_px(3, 1'b1, 1'b0, 8'd71, 7'd40, 3'd2);
      tick();
      chk("t4_x1", 32'(x_to_vga), 71);
      chk("t4_gnt_hold", 32'(gnt), 8);
      req = 4'b0000;
      set_px(3, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      tick();
      chk("t4_rel_gnt", 32'(gnt), 0);
      chk("t4_rel_plot", 32'(plot), 0);
      chk("t4_rel_busy", 32'(busy), 1);
      tick();
      chk("t4_idle_busy", 32'(busy), 0);
      chk("t4_nplots", n_plots - p0, 2);
      req = 4'b1111;
      tick();
      chk("t4_rrptr0", 32'(gnt), 1);
      req = 4'b0000;
      tick();
      chk("t4_abort_gnt", 32'(gnt), 0);
      tick();

      // 5: asynchronous reset mid-burst
      req = 4'b0100;
      tick();
      chk("t5_gnt", 32'(gnt), 4);
      set_px(2, 1'b1, 1'b0, 8'd88, 7'd50, 3'd5);
      tick();
      chk("t5_x", 32'(x_to_vga), 88);
      resetn = 1'b0;
      #1;
      chk("t5_async_gnt", 32'(gnt), 0);
      chk("t5_async_plot", 32'(plot), 0);
      chk("t5_async_xyc", 32'({x_to_vga, y_to_vga, color_to_vga}), 0);
      chk("t5_async_busy", 32'(busy), 0);
      #1;
      resetn = 1'b1;
      set_px(2, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      req = 4'b1001;
      tick();
      chk("t5_post_gnt", 32'(gnt), 1);
      req = 4'b0000;
      tick();
      tick();

      // 6: client 0 streams without last
      req = 4'b0001;
      set_px(0, 1'b1, 1'b0, 8'd0, 7'd60, 3'd6);
      tick();
      chk("t6_gnt", 32'(gnt), 1);
      for (int k = 1; k <= 16; k++) begin
         set_px(0, 1'b1, 1'b0, 8'(k), 7'd60, 3'd6);
         tick();
         eg = (k == 16 && TO == 1) ? 0 : 1;
         chk("t6_burst_gnt", 32'(gnt), eg);
         if (k == 16) chk("t6_timeout", 32'(timeout_err), TO);
      end
      req = 4'b0000;
      set_px(0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
      tick();
      tick();
      chk("t6_end_gnt", 32'(gnt), 0);
      chk("t6_end_busy", 32'(busy), 0);
      chk("t6_sticky", 32'(timeout_err), TO);
      tick();
      chk("t6_sticky2", 32'(timeout_err), TO);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
